// File: rtl/sd_sector_ctrl_pkg.sv
// Shared constants, error codes, state encoding and command framing helper
// for the SD card single-block sector sequencer.
package sd_pkg;

   // Command bytes as they appear on MOSI (start bit + transmission bit + index)
   localparam logic [7:0] CMD17          = 8'h51;   // READ_SINGLE_BLOCK
   localparam logic [7:0] CMD24          = 8'h58;   // WRITE_BLOCK

   // Data tokens and responses
   localparam logic [7:0] TOKEN_START    = 8'hFE;
   localparam logic [7:0] DATA_RESP_OK   = 8'h05;
   localparam logic [7:0] DATA_RESP_MASK = 8'h1F;
   localparam logic [7:0] IDLE_BYTE      = 8'hFF;
   localparam logic [7:0] BUSY_BYTE      = 8'h00;

   // Result codes reported on error at done
   localparam logic [7:0] ERR_OK            = 8'd0;
   localparam logic [7:0] ERR_NO_INIT       = 8'd1;
   localparam logic [7:0] ERR_R1_TIMEOUT    = 8'd2;
   localparam logic [7:0] ERR_R1            = 8'd3;
   localparam logic [7:0] ERR_TOKEN_TIMEOUT = 8'd4;
   localparam logic [7:0] ERR_TOKEN         = 8'd5;
   localparam logic [7:0] ERR_WRESP         = 8'd6;
   localparam logic [7:0] ERR_WBUSY_TIMEOUT = 8'd7;

   // Last index of a 512-byte data block
   localparam logic [9:0] LAST_DATA_BYTE = 10'd511;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_PRE,
      ST_CMD,
      ST_R1,
      ST_TOKEN,
      ST_RDATA,
      ST_RCRC,
      ST_GAP,
      ST_WTOKEN,
      ST_WDATA,
      ST_WCRC,
      ST_WRESP,
      ST_WBUSY,
      ST_FIN
   } state_t;

   // Byte idx of the 6-byte command frame: command, 4 argument bytes MSB
   // first, then a dummy CRC byte (CRC is off in SPI mode).
   function automatic logic [7:0] cmd_frame_byte(input logic [7:0]  cmd,
                                                 input logic [31:0] arg,
                                                 input logic [2:0]  idx);
      logic [7:0] b;
      case (idx)
         3'd0:    b = cmd;
         3'd1:    b = arg[31:24];
         3'd2:    b = arg[23:16];
         3'd3:    b = arg[15:8];
         3'd4:    b = arg[7:0];
         default: b = IDLE_BYTE;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/sd_sector_ctrl_if.sv
// Byte-exchange handshake between the sector sequencer (master) and the
// existing SPI byte engine (slave). Chip select travels with the bus.
interface sd_sector_ctrl_if;
   logic       spi_cs;     // card chip select, active low
   logic       spi_go;     // one-cycle request for one byte exchange
   logic [7:0] spi_tx;     // byte to shift out, stable from go until done
   logic [7:0] spi_rx;     // byte shifted in, valid with done
   logic       spi_done;   // one-cycle completion pulse

   modport master (output spi_cs, spi_go, spi_tx,
                   input  spi_rx, spi_done);

   modport slave  (input  spi_cs, spi_go, spi_tx,
                   output spi_rx, spi_done);
endinterface

// File: rtl/sd_sector_ctrl.sv
// Single-block SD sector sequencer (CMD17 read / CMD24 write) on top of an
// SPI byte-exchange engine. One byte is in flight at a time; every state
// issues exactly one exchange per step and decides on its spi_done.
module sd_sector_ctrl
   import sd_pkg::*;
#(
   parameter int SDHC          = 1,
   parameter int R1_TIMEOUT    = 255,
   parameter int TOKEN_TIMEOUT = 65535
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        init_done,
   input  logic        start,
   input  logic        write,
   input  logic [31:0] lba,
   output logic        busy,
   output logic        done,
   output logic [7:0]  error,
   output logic [7:0]  rd_data,
   output logic        rd_valid,
   input  logic [7:0]  wr_data,
   output logic        wr_req,
   sd_sector_ctrl_if.master spi
);

   localparam logic [15:0] R1_LIMIT    = 16'(R1_TIMEOUT);
   localparam logic [15:0] TOKEN_LIMIT = 16'(TOKEN_TIMEOUT);

   state_t      state_reg,    state_next;
   logic [9:0]  byte_cnt_reg, byte_cnt_next;
   logic [15:0] poll_cnt_reg, poll_cnt_next;
   logic [31:0] arg_reg,      arg_next;
   logic        write_reg,    write_next;
   logic        wait_reg,     wait_next;
   logic        cs_reg,       cs_next;
   logic        go_reg,       go_next;
   logic [7:0]  tx_reg,       tx_next;
   logic        busy_reg,     busy_next;
   logic        done_reg,     done_next;
   logic [7:0]  error_reg,    error_next;
   logic [7:0]  rd_data_reg,  rd_data_next;
   logic        rd_valid_reg, rd_valid_next;
   logic        wr_req_reg,   wr_req_next;

   logic        xfer_done;
   logic        send;
   logic [7:0]  send_byte;
   logic        enter_fin;
   logic [7:0]  fin_code;
   logic [7:0]  cmd_byte;

   // spi_done only counts while an exchange we issued is outstanding
   assign xfer_done = spi.spi_done & wait_reg;
   assign cmd_byte  = write_reg ? CMD24 : CMD17;

   // State and datapath registers; reset aborts any transfer with cs released
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= ST_IDLE;
         byte_cnt_reg <= '0;
         poll_cnt_reg <= '0;
         arg_reg      <= '0;
         write_reg    <= 1'b0;
         wait_reg     <= 1'b0;
         cs_reg       <= 1'b1;
         go_reg       <= 1'b0;
         tx_reg       <= IDLE_BYTE;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         error_reg    <= ERR_OK;
         rd_data_reg  <= '0;
         rd_valid_reg <= 1'b0;
         wr_req_reg   <= 1'b0;
      end else begin
         state_reg    <= state_next;
         byte_cnt_reg <= byte_cnt_next;
         poll_cnt_reg <= poll_cnt_next;
         arg_reg      <= arg_next;
         write_reg    <= write_next;
         wait_reg     <= wait_next;
         cs_reg       <= cs_next;
         go_reg       <= go_next;
         tx_reg       <= tx_next;
         busy_reg     <= busy_next;
         done_reg     <= done_next;
         error_reg    <= error_next;
         rd_data_reg  <= rd_data_next;
         rd_valid_reg <= rd_valid_next;
         wr_req_reg   <= wr_req_next;
      end
   end

   // Next-state, byte selection and status decode for the sector sequence
   always_comb begin
      state_next    = state_reg;
      byte_cnt_next = byte_cnt_reg;
      poll_cnt_next = poll_cnt_reg;
      arg_next      = arg_reg;
      write_next    = write_reg;
      wait_next     = xfer_done ? 1'b0 : wait_reg;
      cs_next       = cs_reg;
      go_next       = 1'b0;
      tx_next       = tx_reg;
      busy_next     = busy_reg;
      done_next     = 1'b0;
      error_next    = error_reg;
      rd_data_next  = rd_data_reg;
      rd_valid_next = 1'b0;
      wr_req_next   = 1'b0;
      send          = 1'b0;
      send_byte     = IDLE_BYTE;
      enter_fin     = 1'b0;
      fin_code      = ERR_OK;

      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               if (!init_done) begin
                  // Refuse without touching the bus
                  done_next  = 1'b1;
                  error_next = ERR_NO_INIT;
               end else begin
                  busy_next  = 1'b1;
                  error_next = ERR_OK;
                  write_next = write;
                  arg_next   = (SDHC != 0) ? lba : {lba[22:0], 9'd0};
                  state_next = ST_PRE;
                  send       = 1'b1;
               end
            end
         end

         ST_PRE: begin
            if (xfer_done) begin
               state_next    = ST_CMD;
               cs_next       = 1'b0;
               byte_cnt_next = '0;
               send          = 1'b1;
               send_byte     = cmd_frame_byte(cmd_byte, arg_reg, 3'd0);
            end
         end

         ST_CMD: begin
            if (xfer_done) begin
               send = 1'b1;
               if (byte_cnt_reg[2:0] == 3'd5) begin
                  state_next    = ST_R1;
                  poll_cnt_next = '0;
               end else begin
                  byte_cnt_next = byte_cnt_reg + 10'd1;
                  send_byte     = cmd_frame_byte(cmd_byte, arg_reg,
                                                 byte_cnt_reg[2:0] + 3'd1);
               end
            end
         end

         ST_R1: begin
            if (xfer_done) begin
               if (spi.spi_rx == IDLE_BYTE) begin
                  if (poll_cnt_reg >= R1_LIMIT) begin
                     enter_fin = 1'b1;
                     fin_code  = ERR_R1_TIMEOUT;
                  end else begin
                     poll_cnt_next = poll_cnt_reg + 16'd1;
                     send          = 1'b1;
                  end
               end else if (spi.spi_rx != 8'h00) begin
                  enter_fin = 1'b1;
                  fin_code  = ERR_R1;
               end else if (write_reg) begin
                  state_next = ST_GAP;
                  send       = 1'b1;
               end else begin
                  state_next    = ST_TOKEN;
                  poll_cnt_next = '0;
                  send          = 1'b1;
               end
            end
         end

         ST_TOKEN: begin
            if (xfer_done) begin
               if (spi.spi_rx == IDLE_BYTE) begin
                  if (poll_cnt_reg >= TOKEN_LIMIT) begin
                     enter_fin = 1'b1;
                     fin_code  = ERR_TOKEN_TIMEOUT;
                  end else begin
                     poll_cnt_next = poll_cnt_reg + 16'd1;
                     send          = 1'b1;
                  end
               end else if (spi.spi_rx == TOKEN_START) begin
                  state_next    = ST_RDATA;
                  byte_cnt_next = '0;
                  send          = 1'b1;
               end else begin
                  enter_fin = 1'b1;
                  fin_code  = ERR_TOKEN;
               end
            end
         end

         ST_RDATA: begin
            if (xfer_done) begin
               rd_valid_next = 1'b1;
               rd_data_next  = spi.spi_rx;
               send          = 1'b1;
               if (byte_cnt_reg == LAST_DATA_BYTE) begin
                  state_next    = ST_RCRC;
                  byte_cnt_next = '0;
               end else begin
                  byte_cnt_next = byte_cnt_reg + 10'd1;
               end
            end
         end

         ST_RCRC: begin
            if (xfer_done) begin
               if (byte_cnt_reg[0]) begin
                  enter_fin = 1'b1;
                  fin_code  = ERR_OK;
               end else begin
                  byte_cnt_next = 10'd1;
                  send          = 1'b1;
               end
            end
         end

         ST_GAP: begin
            if (xfer_done) begin
               state_next = ST_WTOKEN;
               send       = 1'b1;
               send_byte  = TOKEN_START;
            end
         end

         ST_WTOKEN: begin
            if (xfer_done) begin
               state_next    = ST_WDATA;
               byte_cnt_next = '0;
               wr_req_next   = 1'b1;
            end
         end

         ST_WDATA: begin
            // Host byte is requested one cycle ahead and captured into tx
            if (wr_req_reg) begin
               send      = 1'b1;
               send_byte = wr_data;
            end else if (xfer_done) begin
               if (byte_cnt_reg == LAST_DATA_BYTE) begin
                  state_next    = ST_WCRC;
                  byte_cnt_next = '0;
                  send          = 1'b1;
               end else begin
                  byte_cnt_next = byte_cnt_reg + 10'd1;
                  wr_req_next   = 1'b1;
               end
            end
         end

         ST_WCRC: begin
            if (xfer_done) begin
               send = 1'b1;
               if (byte_cnt_reg[0]) begin
                  state_next = ST_WRESP;
               end else begin
                  byte_cnt_next = 10'd1;
               end
            end
         end

         ST_WRESP: begin
            if (xfer_done) begin
               if ((spi.spi_rx & DATA_RESP_MASK) == DATA_RESP_OK) begin
                  state_next    = ST_WBUSY;
                  poll_cnt_next = '0;
                  send          = 1'b1;
               end else begin
                  enter_fin = 1'b1;
                  fin_code  = ERR_WRESP;
               end
            end
         end

         ST_WBUSY: begin
            if (xfer_done) begin
               if (spi.spi_rx == BUSY_BYTE) begin
                  if (poll_cnt_reg >= TOKEN_LIMIT) begin
                     enter_fin = 1'b1;
                     fin_code  = ERR_WBUSY_TIMEOUT;
                  end else begin
                     poll_cnt_next = poll_cnt_reg + 16'd1;
                     send          = 1'b1;
                  end
               end else begin
                  enter_fin = 1'b1;
                  fin_code  = ERR_OK;
               end
            end
         end

         ST_FIN: begin
            if (xfer_done) begin
               state_next = ST_IDLE;
               done_next  = 1'b1;
               busy_next  = 1'b0;
            end
         end

         default: begin
            state_next = ST_IDLE;
            cs_next    = 1'b1;
            busy_next  = 1'b0;
         end
      endcase

      // Success and every error leave through FIN: cs high plus 8 clocks
      if (enter_fin) begin
         state_next = ST_FIN;
         cs_next    = 1'b1;
         error_next = fin_code;
         send       = 1'b1;
         send_byte  = IDLE_BYTE;
      end

      if (send) begin
         go_next   = 1'b1;
         tx_next   = send_byte;
         wait_next = 1'b1;
      end
   end

   assign busy       = busy_reg;
   assign done       = done_reg;
   assign error      = error_reg;
   assign rd_data    = rd_data_reg;
   assign rd_valid   = rd_valid_reg;
   assign wr_req     = wr_req_reg;
   assign spi.spi_cs = cs_reg;
   assign spi.spi_go = go_reg;
   assign spi.spi_tx = tx_reg;

endmodule

// File: tb/tb_sd_sector_ctrl.sv
// Scoreboard bench for sd_sector_ctrl: one block-addressed and one
// byte-addressed instance share a behavioural SPI engine + card model.
module tb_sd_sector_ctrl;

   logic        clock = 1'b0;
   logic        reset_n, init_done, start, write, sel;
   logic [31:0] lba;
   logic [7:0]  wr_data;

   logic        start_hc, start_sc;
   logic        busy_hc, done_hc, rd_valid_hc, wr_req_hc;
   logic        busy_sc, done_sc, rd_valid_sc, wr_req_sc;
   logic [7:0]  error_hc, rd_data_hc, error_sc, rd_data_sc;

   logic [7:0]  m_rx;
   logic        m_done;

   sd_sector_ctrl_if spi_hc();
   sd_sector_ctrl_if spi_sc();

   always #5 clock = ~clock;

   assign start_hc        = start & ~sel;
   assign start_sc        = start & sel;
   assign spi_hc.spi_rx   = m_rx;
   assign spi_sc.spi_rx   = m_rx;
   assign spi_hc.spi_done = m_done & ~sel;
   assign spi_sc.spi_done = m_done & sel;

   sd_sector_ctrl #(.SDHC(1), .R1_TIMEOUT(255), .TOKEN_TIMEOUT(20)) dut_hc (
      .clock(clock), .reset_n(reset_n), .init_done(init_done), .start(start_hc),
      .write(write), .lba(lba), .busy(busy_hc), .done(done_hc), .error(error_hc),
      .rd_data(rd_data_hc), .rd_valid(rd_valid_hc), .wr_data(wr_data),
      .wr_req(wr_req_hc), .spi(spi_hc));

   sd_sector_ctrl #(.SDHC(0), .R1_TIMEOUT(255), .TOKEN_TIMEOUT(20)) dut_sc (
      .clock(clock), .reset_n(reset_n), .init_done(init_done), .start(start_sc),
      .write(write), .lba(lba), .busy(busy_sc), .done(done_sc), .error(error_sc),
      .rd_data(rd_data_sc), .rd_valid(rd_valid_sc), .wr_data(wr_data),
      .wr_req(wr_req_sc), .spi(spi_sc));

   // Selected instance as seen by the card model and the monitor
   logic       busy_m, done_m, rd_valid_m, wr_req_m, cs_m, go_m;
   logic [7:0] error_m, rd_data_m, tx_m;
   assign busy_m     = sel ? busy_sc     : busy_hc;
   assign done_m     = sel ? done_sc     : done_hc;
   assign rd_valid_m = sel ? rd_valid_sc : rd_valid_hc;
   assign wr_req_m   = sel ? wr_req_sc   : wr_req_hc;
   assign error_m    = sel ? error_sc    : error_hc;
   assign rd_data_m  = sel ? rd_data_sc  : rd_data_hc;
   assign cs_m       = sel ? spi_sc.spi_cs : spi_hc.spi_cs;
   assign go_m       = sel ? spi_sc.spi_go : spi_hc.spi_go;
   assign tx_m       = sel ? spi_sc.spi_tx : spi_hc.spi_tx;

   int checks = 0;
   int errors = 0;
   int n_rd = 0, n_wr = 0, n_done = 0, n_go = 0, n_go_lo = 0, n_go_hi = 0;

   logic [7:0] exp_rd[$];
   logic [7:0] exp_mosi[$];
   logic [7:0] exp_done[$];
   logic [7:0] miso_q[$];
   logic [7:0] miso_idle = 8'hFF;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic push_rep(inout logic [7:0] q[$], input logic [7:0] b, input int n);
      for (int i = 0; i < n; i++) q.push_back(b);
   endtask

   // SPI engine + card: 2-cycle exchange; MISO scripted after the 6 command bytes
   initial begin
      int         lowcnt;
      logic [7:0] rx;
      lowcnt = 0;
      m_rx   = 8'hFF;
      m_done = 1'b0;
      forever begin
         @(negedge clock);
         m_done = 1'b0;
         if (reset_n && go_m) begin
            if (cs_m) begin
               lowcnt = 0;
               rx     = 8'hFF;
            end else if (lowcnt < 6) begin
               lowcnt++;
               rx = 8'hFF;
            end else if (miso_q.size() > 0) begin
               rx = miso_q.pop_front();
            end else begin
               rx = miso_idle;
            end
            @(negedge clock);
            @(negedge clock);
            m_rx   = rx;
            m_done = 1'b1;
         end
      end
   end

   // Monitor: compare every presented output against the scoreboard queues
   initial begin
      forever begin
         @(negedge clock);
         if (rd_valid_m) begin
            n_rd++;
            if (exp_rd.size() == 0) begin
               checks++; errors++;
               $display("FAIL rd_unexpected: got rd_data 0x%0h, required no read byte", rd_data_m);
            end else begin
               check("rd_data", rd_data_m, exp_rd.pop_front());
            end
         end
         if (done_m) begin
            n_done++;
            if (exp_done.size() == 0) begin
               checks++; errors++;
               $display("FAIL done_unexpected: got done with error %0d, required no done", error_m);
            end else begin
               check("error_at_done", error_m, exp_done.pop_front());
            end
         end
         if (go_m) begin
            n_go++;
            if (cs_m) n_go_hi++;
            else begin
               n_go_lo++;
               if (exp_mosi.size() > 0) check("mosi", tx_m, exp_mosi.pop_front());
            end
         end
         if (wr_req_m) n_wr++;
      end
   end

   task automatic run_txn(input logic s, input logic w, input logic [31:0] a, input string tag);
      int base;
      base  = n_done;
      sel   = s;
      write = w;
      lba   = a;
      @(negedge clock); start = 1'b1;
      @(negedge clock); start = 1'b0;
      #1 check({tag, "_busy"}, busy_m, 1);
      for (int i = 0; i < 20000 && n_done == base; i++) begin
         @(negedge clock); #1;
      end
      check({tag, "_done_count"}, n_done - base, 1);
      @(negedge clock); #1;
      $display("txn %s: write=%0d lba=0x%08h error=%0d", tag, w, a, error_m);
   endtask

   task automatic push_cmd(input logic [7:0] c, input logic [7:0] b3, input logic [7:0] b2,
                           input logic [7:0] b1, input logic [7:0] b0);
      exp_mosi.push_back(c);  exp_mosi.push_back(b3); exp_mosi.push_back(b2);
      exp_mosi.push_back(b1); exp_mosi.push_back(b0); exp_mosi.push_back(8'hFF);
   endtask

   initial begin
      int b_rd, b_wr, b_go, b_lo, b_hi, b_done;
      reset_n = 1'b0; init_done = 1'b1; start = 1'b0; write = 1'b0;
      sel = 1'b0; lba = '0; wr_data = 8'hA5;

      // Reset state
      repeat (3) @(negedge clock);
      #1;
      check("rst_cs", spi_hc.spi_cs, 1);
      check("rst_cs_sc", spi_sc.spi_cs, 1);
      check("rst_go", go_m, 0);
      check("rst_tx", tx_m, 8'hFF);
      check("rst_busy", busy_m, 0);
      check("rst_done", done_m, 0);
      check("rst_error", error_m, 0);
      check("rst_rd_valid", rd_valid_m, 0);
      check("rst_wr_req", wr_req_m, 0);
      @(negedge clock); reset_n = 1'b1;
      repeat (2) @(negedge clock);

      // Read, block addressing, lba 0x10
      miso_q.push_back(8'h00); miso_q.push_back(8'hFE);
      for (int i = 0; i < 512; i++) begin
         miso_q.push_back(8'(i)); exp_rd.push_back(8'(i));
      end
      push_rep(miso_q, 8'hFF, 2);
      push_cmd(8'h51, 8'h00, 8'h00, 8'h00, 8'h10);
      push_rep(exp_mosi, 8'hFF, 1 + 1 + 512 + 2);
      exp_done.push_back(8'd0);
      b_rd = n_rd; b_hi = n_go_hi; b_wr = n_wr;
      run_txn(1'b0, 1'b0, 32'h0000_0010, "read_hc");
      check("read_rd_count", n_rd - b_rd, 512);
      check("read_rd_left", exp_rd.size(), 0);
      check("read_mosi_left", exp_mosi.size(), 0);
      check("read_cs_high", cs_m, 1);
      check("read_cs_high_bytes", n_go_hi - b_hi, 2);
      check("read_busy_low", busy_m, 0);
      check("read_no_wr_req", n_wr - b_wr, 0);

      // Write, byte addressing, lba 3 -> argument 0x600
      miso_q.push_back(8'h00);
      push_rep(miso_q, 8'hFF, 516);
      miso_q.push_back(8'hE5);
      push_rep(miso_q, 8'h00, 10);
      miso_q.push_back(8'hFF);
      push_cmd(8'h58, 8'h00, 8'h00, 8'h06, 8'h00);
      push_rep(exp_mosi, 8'hFF, 2);
      exp_mosi.push_back(8'hFE);
      push_rep(exp_mosi, 8'hA5, 512);
      push_rep(exp_mosi, 8'hFF, 2 + 1 + 11);
      exp_done.push_back(8'd0);
      b_wr = n_wr; b_rd = n_rd;
      run_txn(1'b1, 1'b1, 32'd3, "write_sc");
      check("write_wr_count", n_wr - b_wr, 512);
      check("write_mosi_left", exp_mosi.size(), 0);
      check("write_no_rd", n_rd - b_rd, 0);
      check("write_cs_high", cs_m, 1);

      // R1 never arrives: 256 polls then error 2
      push_cmd(8'h51, 8'h00, 8'h00, 8'h00, 8'h00);
      push_rep(exp_mosi, 8'hFF, 256);
      exp_done.push_back(8'd2);
      b_lo = n_go_lo; b_hi = n_go_hi; b_rd = n_rd;
      run_txn(1'b0, 1'b0, 32'd0, "r1_timeout");
      check("r1_timeout_lo_bytes", n_go_lo - b_lo, 6 + 256);
      check("r1_timeout_mosi_left", exp_mosi.size(), 0);
      check("r1_timeout_fin", n_go_hi - b_hi, 2);
      check("r1_timeout_no_rd", n_rd - b_rd, 0);

      // R1 reports an error
      miso_q.push_back(8'h04);
      exp_done.push_back(8'd3);
      b_rd = n_rd;
      run_txn(1'b0, 1'b0, 32'd7, "r1_error");
      check("r1_error_no_rd", n_rd - b_rd, 0);

      // Bad data token
      miso_q.push_back(8'h00); miso_q.push_back(8'h08);
      exp_done.push_back(8'd5);
      b_rd = n_rd;
      run_txn(1'b0, 1'b0, 32'd9, "bad_token");
      check("bad_token_no_rd", n_rd - b_rd, 0);

      // Rejected write response
      miso_q.push_back(8'h00);
      push_rep(miso_q, 8'hFF, 516);
      miso_q.push_back(8'h0B);
      exp_done.push_back(8'd6);
      b_wr = n_wr;
      run_txn(1'b1, 1'b1, 32'd1, "wresp_bad");
      check("wresp_bad_wr_count", n_wr - b_wr, 512);

      // Card stays busy past TOKEN_TIMEOUT (20): 21 busy polls then error 7
      miso_q.push_back(8'h00);
      push_rep(miso_q, 8'hFF, 516);
      miso_q.push_back(8'hE5);
      miso_idle = 8'h00;
      exp_done.push_back(8'd7);
      b_lo = n_go_lo;
      run_txn(1'b1, 1'b1, 32'd2, "wbusy_timeout");
      check("wbusy_timeout_lo_bytes", n_go_lo - b_lo, 6 + 1 + 1 + 1 + 512 + 2 + 1 + 21);
      miso_idle = 8'hFF;

      // start without init_done: immediate done, error 1, no SPI traffic
      init_done = 1'b0; sel = 1'b0; write = 1'b0;
      exp_done.push_back(8'd1);
      b_go = n_go; b_done = n_done;
      @(negedge clock); start = 1'b1;
      @(negedge clock); start = 1'b0;
      #1;
      check("noinit_done_next_cycle", done_m, 1);
      check("noinit_busy", busy_m, 0);
      repeat (5) @(negedge clock);
      #1;
      check("noinit_done_count", n_done - b_done, 1);
      check("noinit_no_spi_go", n_go - b_go, 0);
      check("noinit_error_held", error_m, 1);
      $display("txn noinit: error=%0d", error_m);
      init_done = 1'b1;

      // Reset at byte 100 of a read: immediate abort, no done
      miso_q.push_back(8'h00); miso_q.push_back(8'hFE);
      for (int i = 0; i < 512; i++) begin
         miso_q.push_back(8'(i ^ 8'h3C)); exp_rd.push_back(8'(i ^ 8'h3C));
      end
      b_rd = n_rd; b_done = n_done; sel = 1'b0; lba = 32'h55;
      @(negedge clock); start = 1'b1;
      @(negedge clock); start = 1'b0;
      for (int i = 0; i < 20000 && (n_rd - b_rd) < 100; i++) begin
         @(negedge clock); #1;
      end
      check("reset_reached_byte_100", n_rd - b_rd, 100);
      #2 reset_n = 1'b0;
      #1;
      check("reset_cs_high", cs_m, 1);
      check("reset_busy_low", busy_m, 0);
      exp_rd.delete(); exp_mosi.delete(); miso_q.delete();
      repeat (4) @(negedge clock);
      #1;
      check("reset_no_done", n_done - b_done, 0);
      check("reset_error_cleared", error_m, 0);
      $display("txn reset_abort: bytes_before_reset=%0d", n_rd - b_rd);
      @(negedge clock); reset_n = 1'b1;
      repeat (3) @(negedge clock);

      // Recovery after reset
      miso_q.push_back(8'h04);
      exp_done.push_back(8'd3);
      run_txn(1'b0, 1'b0, 32'd4, "after_reset");
      check("final_done_queue_empty", exp_done.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
